// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver with optional parity and an AXI-stream output FIFO.
//
// Ports:
//   clk           in   sole clock, rising edge
//   rst           in   asynchronous active-high reset
//   i_uart_rx     in   UART line, idle high, asynchronous to clk
//   o_tready      in   AXI-stream TREADY from the consumer
//   o_tvalid      out  FIFO holds at least one byte
//   o_tdata       out  byte at the FIFO head (0 after reset)
//   o_parity_err  out  one-cycle pulse: frame dropped on parity mismatch
//   o_frame_err   out  one-cycle pulse: frame dropped, stop bit sampled low
//   o_overflow    out  one-cycle pulse: good byte dropped, FIFO full
//
// Parameters:
//   CLK_FREQ, BAUD_RATE  bit period = round(CLK_FREQ / BAUD_RATE) clocks
//   PARITY               "NONE", "ODD" or "EVEN"
//   FIFO_EA              FIFO depth = 2**FIFO_EA bytes (FIFO_EA >= 1)
module uart_rx #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter logic [31:0] PARITY    = "NONE",
    parameter int unsigned FIFO_EA   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_uart_rx,
    input  logic       o_tready,
    output logic       o_tvalid,
    output logic [7:0] o_tdata,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_overflow
);

    localparam int unsigned BAUD_CYCLES = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int unsigned HALF_CYCLES = BAUD_CYCLES / 2;
    localparam logic [31:0] BAUD_LAST   = 32'(BAUD_CYCLES - 1);
    localparam logic [31:0] HALF_LAST   = (HALF_CYCLES > 0) ? 32'(HALF_CYCLES - 1) : 32'd0;

    localparam logic [31:0] PAR_ODD_STR  = {8'd0, "ODD"};
    localparam logic [31:0] PAR_EVEN_STR = "EVEN";
    localparam bit          PAR_ODD      = (PARITY == PAR_ODD_STR);
    localparam bit          PAR_EN       = PAR_ODD || (PARITY == PAR_EVEN_STR);

    localparam int unsigned DEPTH = 1 << FIFO_EA;
    localparam int unsigned PW    = FIFO_EA + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    // ------------------------------------------------------------------
    // Line synchronizer (resets to idle-high so reset never looks like a start)
    // ------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_uart_rx};
        end
    end

    assign rx_s = sync_q[1];

    // ------------------------------------------------------------------
    // Receive FSM state and datapath registers
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_bad_q, par_bad_d;
    logic        perr_q, perr_d;
    logic        ferr_q, ferr_d;
    logic        ovf_q, ovf_d;
    logic        push_c;
    logic        par_exp_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 32'd0;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
        end
    end

    // Expected parity bit for the byte just shifted in
    assign par_exp_c = PAR_ODD ? ~^shift_q : ^shift_q;

    // Next-state logic; the bit counter restarts at every sample point so
    // rounding error never accumulates across the frame
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 32'd1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        push_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d     = 32'd0;
                par_bad_d = 1'b0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = 32'd0;
                    bit_d   = 3'd0;
                    // A start bit that is high again at mid-bit was a glitch
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end

            S_DATA: begin
                if (cnt_q == BAUD_LAST) begin
                    cnt_d   = 32'd0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = PAR_EN ? S_PARITY : S_STOP;
                    end
                end
            end

            S_PARITY: begin
                if (cnt_q == BAUD_LAST) begin
                    cnt_d     = 32'd0;
                    par_bad_d = (rx_s != par_exp_c);
                    state_d   = S_STOP;
                end
            end

            S_STOP: begin
                if (cnt_q == BAUD_LAST) begin
                    cnt_d = 32'd0;
                    // Framing error outranks parity error
                    if (!rx_s) begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end else begin
                        state_d = S_IDLE;
                        if (par_bad_q) begin
                            perr_d = 1'b1;
                        end else begin
                            push_c = 1'b1;
                        end
                    end
                end
            end

            S_WAIT_HIGH: begin
                // A line stuck low (break) must not be taken as a new start
                cnt_d = 32'd0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = 32'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output FIFO: pointers carry one extra wrap bit to tell full from empty
    // ------------------------------------------------------------------
    logic [7:0]         mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [FIFO_EA-1:0] wr_idx, rd_idx;
    logic               empty_c, full_c, pop_c, push_ok_c;

    assign wr_idx    = wr_ptr_q[FIFO_EA-1:0];
    assign rd_idx    = rd_ptr_q[FIFO_EA-1:0];
    assign empty_c   = (wr_ptr_q == rd_ptr_q);
    assign full_c    = (wr_ptr_q[FIFO_EA] != rd_ptr_q[FIFO_EA]) && (wr_idx == rd_idx);
    assign pop_c     = !empty_c && o_tready;
    // A pop in the same cycle frees the slot the push lands in
    assign push_ok_c = push_c && (!full_c || pop_c);
    assign ovf_d     = push_c && full_c && !pop_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok_c) begin
                mem_q[wr_idx] <= shift_q;
                wr_ptr_q      <= wr_ptr_q + PW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_tvalid     = !empty_c;
    assign o_tdata      = mem_q[rd_idx];
    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;
    assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 1 MHz / 100 kbaud (10 clocks per bit).
// Two instances share clock and reset: dut_n without parity, dut_e with even parity.
module tb_uart_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       line_n, line_e;
    logic       rdy_n, rdy_e;
    logic       tv_n, tv_e;
    logic [7:0] td_n, td_e;
    logic       perr_n, perr_e, ferr_n, ferr_e, ovf_n, ovf_e;

    uart_rx #(
        .CLK_FREQ (1000000),
        .BAUD_RATE(100000),
        .PARITY   ("NONE"),
        .FIFO_EA  (2)
    ) dut_n (
        .clk         (clk),
        .rst         (rst),
        .i_uart_rx   (line_n),
        .o_tready    (rdy_n),
        .o_tvalid    (tv_n),
        .o_tdata     (td_n),
        .o_parity_err(perr_n),
        .o_frame_err (ferr_n),
        .o_overflow  (ovf_n)
    );

    uart_rx #(
        .CLK_FREQ (1000000),
        .BAUD_RATE(100000),
        .PARITY   ("EVEN"),
        .FIFO_EA  (2)
    ) dut_e (
        .clk         (clk),
        .rst         (rst),
        .i_uart_rx   (line_e),
        .o_tready    (rdy_e),
        .o_tvalid    (tv_e),
        .o_tdata     (td_e),
        .o_parity_err(perr_e),
        .o_frame_err (ferr_e),
        .o_overflow  (ovf_e)
    );

    int checks = 0;
    int errors = 0;

    // Monitor: accepted beats and high cycles of each pulse output
    logic [7:0] q_n[$];
    logic [7:0] q_e[$];
    int np_n = 0, nf_n = 0, no_n = 0;
    int np_e = 0, nf_e = 0, no_e = 0;

    always @(negedge clk) begin
        if (tv_n && rdy_n) q_n.push_back(td_n);
        if (tv_e && rdy_e) q_e.push_back(td_e);
        if (perr_n) np_n++;
        if (ferr_n) nf_n++;
        if (ovf_n)  no_n++;
        if (perr_e) np_e++;
        if (ferr_e) nf_e++;
        if (ovf_e)  no_e++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel_e, input logic v);
        if (sel_e) line_e = v;
        else       line_n = v;
    endtask

    // One frame: start, 8 data LSB first, optional parity, stop held stop_len clocks, then idle
    task automatic send(input bit sel_e, input logic [7:0] b, input bit use_par,
                        input logic par, input logic stop_v, input int stop_len);
        drive(sel_e, 1'b0);
        cyc(10);
        for (int i = 0; i < 8; i++) begin
            drive(sel_e, b[i]);
            cyc(10);
        end
        if (use_par) begin
            drive(sel_e, par);
            cyc(10);
        end
        drive(sel_e, stop_v);
        cyc(stop_len);
        drive(sel_e, 1'b1);
        cyc(10);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tvalid_n"}, 32'(tv_n),   32'd0);
        chk({tag, "_tdata_n"},  32'(td_n),   32'd0);
        chk({tag, "_perr_n"},   32'(perr_n), 32'd0);
        chk({tag, "_ferr_n"},   32'(ferr_n), 32'd0);
        chk({tag, "_ovf_n"},    32'(ovf_n),  32'd0);
        chk({tag, "_tvalid_e"}, 32'(tv_e),   32'd0);
        chk({tag, "_tdata_e"},  32'(td_e),   32'd0);
        chk({tag, "_perr_e"},   32'(perr_e), 32'd0);
        chk({tag, "_ferr_e"},   32'(ferr_e), 32'd0);
        chk({tag, "_ovf_e"},    32'(ovf_e),  32'd0);
    endtask

    initial begin
        int bq, be, ep, ef, eo;
        logic [7:0] b;

        rst    = 1'b1;
        line_n = 1'b1;
        line_e = 1'b1;
        rdy_n  = 1'b1;
        rdy_e  = 1'b1;
        cyc(5);
        chk_zero("reset");
        rst = 1'b0;
        cyc(5);

        // Clean 0x55, no parity
        bq = q_n.size(); ep = np_n; ef = nf_n; eo = no_n;
        send(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 10);
        chk("n55_beats", 32'(q_n.size() - bq), 32'd1);
        chk("n55_data",  32'(q_n[bq]), 32'h55);
        chk("n55_perr",  32'(np_n - ep), 32'd0);
        chk("n55_ferr",  32'(nf_n - ef), 32'd0);
        chk("n55_ovf",   32'(no_n - eo), 32'd0);

        // 3-cycle glitch: ignored, then a real frame still decodes
        bq = q_n.size(); ep = np_n; ef = nf_n; eo = no_n;
        drive(1'b0, 1'b0);
        cyc(3);
        drive(1'b0, 1'b1);
        cyc(20);
        chk("glitch_beats", 32'(q_n.size() - bq), 32'd0);
        chk("glitch_errs",  32'((np_n - ep) + (nf_n - ef) + (no_n - eo)), 32'd0);
        send(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, 10);
        chk("after_glitch_beats", 32'(q_n.size() - bq), 32'd1);
        chk("after_glitch_data",  32'(q_n[bq]), 32'hC3);

        // Even parity: 0xA5 with wrong parity 1 dropped, 0x3C with parity 0 kept
        be = q_e.size(); ep = np_e; ef = nf_e;
        send(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 10);
        chk("par_bad_perr",  32'(np_e - ep), 32'd1);
        chk("par_bad_ferr",  32'(nf_e - ef), 32'd0);
        chk("par_bad_beats", 32'(q_e.size() - be), 32'd0);
        send(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 10);
        chk("par_ok_beats", 32'(q_e.size() - be), 32'd1);
        chk("par_ok_data",  32'(q_e[be]), 32'h3C);
        chk("par_ok_perr",  32'(np_e - ep), 32'd1);

        // Framing error: 0x12 with stop low and line held low 30 clocks
        bq = q_n.size(); ep = np_n; ef = nf_n;
        send(1'b0, 8'h12, 1'b0, 1'b0, 1'b0, 30);
        chk("frm_ferr",  32'(nf_n - ef), 32'd1);
        chk("frm_perr",  32'(np_n - ep), 32'd0);
        chk("frm_beats", 32'(q_n.size() - bq), 32'd0);
        cyc(10);
        send(1'b0, 8'h34, 1'b0, 1'b0, 1'b1, 10);
        chk("frm_next_beats", 32'(q_n.size() - bq), 32'd1);
        chk("frm_next_data",  32'(q_n[bq]), 32'h34);
        chk("frm_next_ferr",  32'(nf_n - ef), 32'd1);

        // Overflow: depth 4, consumer stalled, fifth byte dropped
        rdy_n = 1'b0;
        bq = q_n.size(); eo = no_n;
        for (int i = 1; i <= 4; i++) begin
            b = 8'(i);
            send(1'b0, b, 1'b0, 1'b0, 1'b1, 10);
        end
        chk("ovf_before",     32'(no_n - eo), 32'd0);
        chk("ovf_hold_valid", 32'(tv_n), 32'd1);
        chk("ovf_hold_data",  32'(td_n), 32'h01);
        send(1'b0, 8'h05, 1'b0, 1'b0, 1'b1, 10);
        chk("ovf_pulse",      32'(no_n - eo), 32'd1);
        chk("ovf_still_head", 32'(td_n), 32'h01);
        rdy_n = 1'b1;
        cyc(10);
        chk("ovf_drain_beats", 32'(q_n.size() - bq), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_drain_data", 32'(q_n[bq + i]), 32'(i + 1));
        end
        chk("ovf_drain_empty", 32'(tv_n), 32'd0);
        chk("ovf_no_more",     32'(no_n - eo), 32'd1);

        // Park a byte in dut_e so reset has something to flush
        rdy_e = 1'b0;
        send(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 10);
        chk("park_valid", 32'(tv_e), 32'd1);
        chk("park_data",  32'(td_e), 32'h5A);

        // Reset during data bit 4 of 0x77
        b = 8'h77;
        drive(1'b0, 1'b0);
        cyc(10);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, b[i]);
            cyc(10);
        end
        drive(1'b0, b[4]);
        cyc(5);
        rst = 1'b1;
        #1;
        chk_zero("rst_async");
        cyc(3);
        rst = 1'b0;
        drive(1'b0, 1'b1);
        cyc(30);
        chk_zero("rst_after");
        rdy_e = 1'b1;
        be = q_e.size();
        bq = q_n.size(); ep = np_n; ef = nf_n; eo = no_n;
        send(1'b0, 8'h88, 1'b0, 1'b0, 1'b1, 10);
        chk("post_rst_beats", 32'(q_n.size() - bq), 32'd1);
        chk("post_rst_data",  32'(q_n[bq]), 32'h88);
        chk("post_rst_errs",  32'((np_n - ep) + (nf_n - ef) + (no_n - eo)), 32'd0);
        chk("post_rst_e_empty", 32'(q_e.size() - be), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
